// File: rtl/regfile_multiport.sv
// regfile_multiport
//   Integer register file for the decode stage. NRD registered read ports,
//   one writeback port, optional write-to-read bypass and a per-register
//   pending bit used by decode to detect read-after-write hazards.
//   Register 0 is hard-wired to zero and is never pending.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous reset, active high, clears registers, pending bits and read outputs
//   i_rd_en      capture read data/busy this cycle; 0 holds o_rd_data/o_rd_busy
//   i_rd_addr    read addresses, port p at [p*AW +: AW]
//   o_rd_data    registered read data, port p at [p*XLEN +: XLEN]
//   o_rd_busy    registered: addressed register was pending when captured
//   i_issue_en   mark i_issue_rd pending
//   i_issue_rd   destination register of the issued instruction
//   i_wb_en      writeback valid (always accepted)
//   i_wb_addr    writeback destination
//   i_wb_data    writeback data
//   o_debug      combinational view of register DEBUG_REG after the last edge
module regfile_multiport #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int NRD       = 2,
    parameter int BYPASS    = 1,
    parameter int DEBUG_REG = 10,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_rd_en,
    input  logic [NRD*AW-1:0]   i_rd_addr,
    output logic [NRD*XLEN-1:0] o_rd_data,
    output logic [NRD-1:0]      o_rd_busy,
    input  logic                i_issue_en,
    input  logic [AW-1:0]       i_issue_rd,
    input  logic                i_wb_en,
    input  logic [AW-1:0]       i_wb_addr,
    input  logic [XLEN-1:0]     i_wb_data,
    output logic [XLEN-1:0]     o_debug
);

    localparam logic [AW-1:0] DBG_IDX = AW'(DEBUG_REG);

    logic [XLEN-1:0]     regs [NREGS];
    logic [NREGS-1:0]    pending;
    logic [NREGS-1:0]    pending_nxt;
    logic [NRD*XLEN-1:0] rd_data_nxt;
    logic [NRD-1:0]      rd_busy_nxt;
    logic                wb_valid;
    logic                issue_valid;

    assign wb_valid    = i_wb_en && (i_wb_addr != '0);
    assign issue_valid = i_issue_en && (i_issue_rd != '0);

    // Issue is applied after writeback so a same-cycle issue to the register
    // being written leaves it pending: the newer producer is still in flight.
    always_comb begin
        pending_nxt = pending;
        if (wb_valid) begin
            pending_nxt[i_wb_addr] = 1'b0;
        end
        if (issue_valid) begin
            pending_nxt[i_issue_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    // Reads see pre-edge pending bits; a same-cycle writeback (when bypassed)
    // both supplies the data and resolves the hazard.
    always_comb begin
        rd_data_nxt = '0;
        rd_busy_nxt = '0;
        for (int p = 0; p < NRD; p++) begin
            logic [AW-1:0] addr;
            logic          hit;
            addr = i_rd_addr[p*AW +: AW];
            hit  = (BYPASS != 0) && i_wb_en && (i_wb_addr == addr);
            rd_data_nxt[p*XLEN +: XLEN] = (hit && (addr != '0)) ? i_wb_data : regs[addr];
            rd_busy_nxt[p]              = pending[addr] && !hit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            pending   <= '0;
            o_rd_data <= '0;
            o_rd_busy <= '0;
        end else begin
            if (wb_valid) begin
                regs[i_wb_addr] <= i_wb_data;
            end
            pending <= pending_nxt;
            if (i_rd_en) begin
                o_rd_data <= rd_data_nxt;
                o_rd_busy <= rd_busy_nxt;
            end
        end
    end

    // regs[0] is never written after reset, so DEBUG_REG==0 yields zero.
    assign o_debug = regs[DBG_IDX];

endmodule

// File: tb/tb_regfile_multiport.sv
module tb_regfile_multiport;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rst;
    logic                rd_en;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data_b, rd_data_n;
    logic [NRD-1:0]      rd_busy_b, rd_busy_n;
    logic                issue_en;
    logic [AW-1:0]       issue_rd;
    logic                wb_en;
    logic [AW-1:0]       wb_addr;
    logic [XLEN-1:0]     wb_data;
    logic [XLEN-1:0]     debug_b, debug_n;

    always #5 clk = ~clk;

    regfile_multiport #(.BYPASS(1)) dut (
        .clk(clk), .rst(rst), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
        .o_rd_data(rd_data_b), .o_rd_busy(rd_busy_b),
        .i_issue_en(issue_en), .i_issue_rd(issue_rd),
        .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
        .o_debug(debug_b)
    );

    regfile_multiport #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .i_rd_en(rd_en), .i_rd_addr(rd_addr),
        .o_rd_data(rd_data_n), .o_rd_busy(rd_busy_n),
        .i_issue_en(issue_en), .i_issue_rd(issue_rd),
        .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
        .o_debug(debug_n)
    );

    typedef struct packed {
        logic [NRD*XLEN-1:0] data_b;
        logic [NRD*XLEN-1:0] data_n;
        logic [NRD-1:0]      busy_b;
        logic [NRD-1:0]      busy_n;
    } exp_t;

    exp_t             sb_q[$];
    exp_t             held;
    logic [XLEN-1:0]  m_reg [NREGS];
    logic [NREGS-1:0] m_pend;
    int               n_checks = 0;
    int               n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst      = 1'b0;
        rd_en    = 1'b0;
        issue_en = 1'b0;
        issue_rd = '0;
        wb_en    = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
    endtask

    task automatic set_rd(input int a0, input int a1);
        rd_en   = 1'b1;
        rd_addr = {AW'(a1), AW'(a0)};
    endtask

    task automatic set_wb(input int a, input logic [XLEN-1:0] d);
        wb_en   = 1'b1;
        wb_addr = AW'(a);
        wb_data = d;
    endtask

    task automatic set_issue(input int a);
        issue_en = 1'b1;
        issue_rd = AW'(a);
    endtask

    // One clock: predict captured outputs from the model, push, advance,
    // then pop and compare against both instances.
    task automatic tick();
        exp_t e;
        exp_t got;
        e = held;
        if (rst) begin
            e = '0;
            for (int i = 0; i < NREGS; i++) m_reg[i] = '0;
            m_pend = '0;
        end else begin
            if (rd_en) begin
                for (int p = 0; p < NRD; p++) begin
                    logic [AW-1:0] a;
                    logic          hit;
                    a   = rd_addr[p*AW +: AW];
                    hit = wb_en && (wb_addr == a);
                    e.data_b[p*XLEN +: XLEN] = (a == 0) ? '0 : (hit ? wb_data : m_reg[a]);
                    e.data_n[p*XLEN +: XLEN] = (a == 0) ? '0 : m_reg[a];
                    e.busy_b[p] = (a != 0) && m_pend[a] && !hit;
                    e.busy_n[p] = (a != 0) && m_pend[a];
                end
            end
            if (wb_en && wb_addr != 0) begin
                m_reg[wb_addr]  = wb_data;
                m_pend[wb_addr] = 1'b0;
            end
            if (issue_en && issue_rd != 0) m_pend[issue_rd] = 1'b1;
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 64'(sb_q.size()), 64'd1);
        end else begin
            got  = sb_q.pop_front();
            held = got;
            check("rd_data_byp", rd_data_b, got.data_b);
            check("rd_busy_byp", 64'(rd_busy_b), 64'(got.busy_b));
            check("rd_data_nobyp", rd_data_n, got.data_n);
            check("rd_busy_nobyp", 64'(rd_busy_n), 64'(got.busy_n));
        end
        check("debug", 64'(debug_b), 64'(m_reg[10]));
        check("debug_nb", 64'(debug_n), 64'(m_reg[10]));
    endtask

    initial begin
        held    = '0;
        m_pend  = '0;
        rd_addr = '0;
        idle();
        rst = 1'b1;
        tick();

        // 1: reset clears a written register
        idle(); set_wb(5, 32'hDEAD_BEEF); tick();
        idle(); rst = 1'b1; set_rd(5, 5); tick();
        idle(); set_rd(5, 5); tick();
        check("t1_data", 64'(rd_data_b[31:0]), 64'h0);
        check("t1_busy", 64'(rd_busy_b[0]), 64'h0);
        check("t1_debug", 64'(debug_b), 64'h0);

        // 2: x0 ignores writes and issues
        idle(); set_wb(0, 32'h1234); set_issue(0); tick();
        idle(); set_rd(0, 0); tick();
        check("t2_data", rd_data_b, 64'h0);
        check("t2_busy", 64'(rd_busy_b), 64'h0);

        // 3: bypass vs no bypass on port 1
        idle(); set_wb(7, 32'h1); tick();
        idle(); set_wb(7, 32'hA5A5_0001); set_rd(0, 7); tick();
        check("t3_byp", 64'(rd_data_b[63:32]), 64'hA5A5_0001);
        check("t3_byp_busy", 64'(rd_busy_b[1]), 64'h0);
        check("t3_nobyp", 64'(rd_data_n[63:32]), 64'h1);

        // 4: pending scoreboard
        idle(); set_issue(3); tick();
        idle(); set_rd(3, 0); tick();
        check("t4_busy", 64'(rd_busy_b[0]), 64'h1);
        idle(); set_wb(3, 32'h42); tick();
        idle(); set_rd(3, 0); tick();
        check("t4_data", 64'(rd_data_b[31:0]), 64'h42);
        check("t4_clear", 64'(rd_busy_b[0]), 64'h0);

        // 5: same-cycle issue and writeback leaves register pending
        idle(); set_issue(9); tick();
        idle(); set_issue(9); set_wb(9, 32'h77); tick();
        idle(); set_rd(9, 9); tick();
        check("t5_data", 64'(rd_data_b[31:0]), 64'h77);
        check("t5_busy", 64'(rd_busy_b), 64'h3);

        // 6: stall holds, debug follows x10
        idle(); set_wb(4, 32'h10); tick();
        idle(); set_rd(4, 4); tick();
        check("t6_first", 64'(rd_data_b[31:0]), 64'h10);
        for (int i = 0; i < 3; i++) begin
            idle(); set_wb(4, 32'h20); tick();
            check("t6_hold", 64'(rd_data_b[31:0]), 64'h10);
        end
        idle(); set_rd(4, 4); tick();
        check("t6_resume", 64'(rd_data_b[31:0]), 64'h20);
        idle(); set_wb(10, 32'hCAFE); tick();
        check("t6_debug", 64'(debug_b), 64'hCAFE);

        // Random traffic against the model
        for (int n = 0; n < 300; n++) begin
            idle();
            rst      = ($urandom_range(0, 63) == 0);
            rd_en    = $urandom_range(0, 3) != 0;
            rd_addr  = {AW'($urandom_range(0, 11)), AW'($urandom_range(0, 11))};
            issue_en = $urandom_range(0, 2) == 0;
            issue_rd = AW'($urandom_range(0, 11));
            wb_en    = $urandom_range(0, 1) == 0;
            wb_addr  = AW'($urandom_range(0, 11));
            wb_data  = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
